// File: rtl/julia_pkg.sv
`default_nettype none
// julia_pkg -- shared FSM state type and frame constants for the Julia result path.
// Rev 1.0
package julia_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } arb_state_t;

  localparam int FRAME_PIXELS = 640 * 480;
  // Linear frame-buffer address width, sized from the full-resolution frame.
  localparam int FB_ADDR_W = $clog2(FRAME_PIXELS);

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// rr_arbiter -- round-robin one-hot grant; search starts just after the last granted index.
// Rev 1.0
module rr_arbiter #(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] grant
);

  localparam int PTR_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(N - 1);

  logic [PTR_W-1:0] last_q;
  logic [PTR_W-1:0] grant_idx;
  logic [PTR_W-1:0] idx;
  logic             found;

  always_comb begin
    grant     = '0;
    grant_idx = last_q;
    idx       = last_q;
    found     = 1'b0;
    for (int k = 1; k <= N; k++) begin
      idx = PTR_W'((int'(last_q) + k) % N);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        grant_idx  = idx;
        found      = 1'b1;
      end
    end
  end

  // Reset pointer sits on the last index so worker 0 is searched first.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= LAST_IDX;
    end else if (advance && found) begin
      last_q <= grant_idx;
    end
  end

endmodule
`default_nettype wire

// File: rtl/result_arbiter.sv
`default_nettype none
// result_arbiter -- collects Julia worker pixels into one frame-buffer write stream. Rev 1.0
// Optional stall statistics output enabled by defining RESULT_ARB_STATS_EN.
module result_arbiter
  import julia_pkg::*;
#(
  parameter int NUM_WORKERS = 16,
  parameter int ITER_W      = 8,
  parameter int X_MAX       = 639,
  parameter int Y_MAX       = 479
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [NUM_WORKERS-1:0]      jw_ra_valid,
  input  logic [NUM_WORKERS*10-1:0]   jw_ra_x,
  input  logic [NUM_WORKERS*10-1:0]   jw_ra_y,
  input  logic [NUM_WORKERS*ITER_W-1:0] jw_ra_iter,
  output logic [NUM_WORKERS-1:0]      ra_jw_ack,
  output logic                        fb_wr_valid,
  input  logic                        fb_wr_ready,
  output logic [FB_ADDR_W-1:0]        fb_wr_addr,
  output logic [ITER_W-1:0]           fb_wr_data,
  output logic                        frame_done,
`ifdef RESULT_ARB_STATS_EN
  output logic [31:0]                 stall_cycles,
`endif
  output logic                        oob_err
);

  localparam logic [FB_ADDR_W-1:0] FRAME   = FB_ADDR_W'((X_MAX + 1) * (Y_MAX + 1));
  localparam logic [FB_ADDR_W-1:0] ROW_LEN = FB_ADDR_W'(X_MAX + 1);
  localparam logic [9:0]           X_LIM   = 10'(X_MAX);
  localparam logic [9:0]           Y_LIM   = 10'(Y_MAX);

  arb_state_t               state;
  arb_state_t               state_nxt;
  logic [FB_ADDR_W-1:0]     written;
  logic [FB_ADDR_W-1:0]     written_nxt;
  logic [NUM_WORKERS-1:0]   grant;
  logic [9:0]               sel_x;
  logic [9:0]               sel_y;
  logic [ITER_W-1:0]        sel_iter;
  logic                     hs;
  logic                     cap_en;
  logic                     cap;
  logic                     cap_oob;
  logic                     load;
  logic                     pend_nxt;

  assign hs          = fb_wr_valid & fb_wr_ready;
  assign cap_en      = !rst && (state == ST_RUN) && (!fb_wr_valid || hs);
  assign cap         = cap_en && (|jw_ra_valid);
  assign ra_jw_ack   = cap_en ? grant : '0;
  assign cap_oob     = (sel_x > X_LIM) || (sel_y > Y_LIM);
  assign load        = cap && !cap_oob;
  assign pend_nxt    = load | (fb_wr_valid & ~hs);
  assign written_nxt = written + FB_ADDR_W'(hs);
  assign frame_done  = (state == ST_DONE);

  rr_arbiter #(
    .N(NUM_WORKERS)
  ) u_rr_arbiter (
    .clk    (clk),
    .rst    (rst),
    .req    (jw_ra_valid),
    .advance(cap_en),
    .grant  (grant)
  );

  always_comb begin
    sel_x    = '0;
    sel_y    = '0;
    sel_iter = '0;
    for (int i = 0; i < NUM_WORKERS; i++) begin
      if (grant[i]) begin
        sel_x    = jw_ra_x[i*10 +: 10];
        sel_y    = jw_ra_y[i*10 +: 10];
        sel_iter = jw_ra_iter[i*ITER_W +: ITER_W];
      end
    end
  end

  // Leave RUN once every frame pixel is either written or sitting in the output register.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start) state_nxt = ST_RUN;
      ST_RUN:   if (written_nxt + FB_ADDR_W'(pend_nxt) == FRAME) state_nxt = ST_DRAIN;
      ST_DRAIN: if (hs) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      written     <= '0;
      fb_wr_valid <= 1'b0;
      fb_wr_addr  <= '0;
      fb_wr_data  <= '0;
      oob_err     <= 1'b0;
    end else begin
      state       <= state_nxt;
      fb_wr_valid <= pend_nxt;
      if (state == ST_IDLE && start) begin
        written <= '0;
      end else begin
        written <= written_nxt;
      end
      if (load) begin
        fb_wr_addr <= FB_ADDR_W'(sel_y) * ROW_LEN + FB_ADDR_W'(sel_x);
        fb_wr_data <= sel_iter;
      end
      if (cap && cap_oob) begin
        oob_err <= 1'b1;
      end
    end
  end

`ifdef RESULT_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
    end else if (state == ST_IDLE && start) begin
      stall_cycles <= '0;
    end else if ((state == ST_RUN || state == ST_DRAIN) && fb_wr_valid && !fb_wr_ready
                 && (stall_cycles != 32'hFFFF_FFFF)) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_result_arbiter.sv
`default_nettype none
// tb_result_arbiter -- directed table, hand-written corner sequences and a randomized
// frame checked against a behavioural model. Reduced frame height keeps the run short.
module tb_result_arbiter;

  localparam int N     = 16;
  localparam int IW    = 8;
  localparam int XM    = 639;
  localparam int YM    = 3;
  localparam int FRAME = (XM + 1) * (YM + 1);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst, start, ready;
  logic [N-1:0]    valid;
  logic [9:0]      wx [N];
  logic [9:0]      wy [N];
  logic [IW-1:0]   wit [N];
  logic [N*10-1:0] x_bus, y_bus;
  logic [N*IW-1:0] it_bus;

  logic [N-1:0]    ack;
  logic            fbv, done, oob;
  logic [18:0]     addr;
  logic [IW-1:0]   data;
`ifdef RESULT_ARB_STATS_EN
  logic [31:0]     stall;
`endif

  always_comb begin
    x_bus  = '0;
    y_bus  = '0;
    it_bus = '0;
    for (int i = 0; i < N; i++) begin
      x_bus[i*10 +: 10]  = wx[i];
      y_bus[i*10 +: 10]  = wy[i];
      it_bus[i*IW +: IW] = wit[i];
    end
  end

  result_arbiter #(
    .NUM_WORKERS(N), .ITER_W(IW), .X_MAX(XM), .Y_MAX(YM)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .jw_ra_valid(valid), .jw_ra_x(x_bus), .jw_ra_y(y_bus), .jw_ra_iter(it_bus),
    .ra_jw_ack(ack), .fb_wr_valid(fbv), .fb_wr_ready(ready),
    .fb_wr_addr(addr), .fb_wr_data(data), .frame_done(done),
`ifdef RESULT_ARB_STATS_EN
    .stall_cycles(stall),
`endif
    .oob_err(oob)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  // Behavioural model: frame phase 0=idle 1=collecting 2=draining 3=done.
  int     m_phase, m_addr, m_data, m_last, m_written, m_cap, cyc, hs_total, last_hs_cyc;
  bit     m_pend, m_oob;
  longint m_stall;

  task automatic model_reset();
    m_phase = 0; m_pend = 0; m_addr = 0; m_data = 0; m_last = N - 1;
    m_written = 0; m_oob = 0; m_stall = 0; m_cap = -1;
  endtask

  function automatic int next_worker();
    for (int k = 1; k <= N; k++) begin
      if (valid[(m_last + k) % N]) return (m_last + k) % N;
    end
    return -1;
  endfunction

  task automatic cycle_begin();
    logic [N-1:0] e;
    #1;
    e = '0;
    m_cap = (!rst && m_phase == 1 && (!m_pend || ready)) ? next_worker() : -1;
    if (m_cap >= 0) e[m_cap] = 1'b1;
    chk("m_ack", 64'(ack), 64'(e));
    chk("m_fb_valid", 64'(fbv), 64'(m_pend));
    if (m_pend) begin
      chk("m_addr", 64'(addr), 64'(m_addr));
      chk("m_data", 64'(data), 64'(m_data));
    end
    chk("m_frame_done", 64'(done), 64'(m_phase == 3));
    chk("m_oob_err", 64'(oob), 64'(m_oob));
`ifdef RESULT_ARB_STATS_EN
    chk("m_stall", 64'(stall), 64'(m_stall));
`endif
  endtask

  task automatic cycle_end();
    bit hs, np;
    @(posedge clk);
    hs = m_pend && ready;
    if (rst) begin
      model_reset();
    end else begin
      if ((m_phase == 1 || m_phase == 2) && m_pend && !ready && m_stall < 64'hFFFF_FFFF) m_stall++;
      if (hs) begin m_written++; hs_total++; last_hs_cyc = cyc; end
      np = m_pend && !hs;
      if (m_cap >= 0) begin
        m_last = m_cap;
        if (int'(wx[m_cap]) > XM || int'(wy[m_cap]) > YM) m_oob = 1;
        else begin
          np = 1; m_addr = int'(wy[m_cap]) * (XM + 1) + int'(wx[m_cap]); m_data = int'(wit[m_cap]);
        end
      end
      m_pend = np;
      case (m_phase)
        0: if (start) begin m_phase = 1; m_written = 0; m_stall = 0; end
        1: if (m_written + int'(m_pend) == FRAME) m_phase = 2;
        2: if (hs) m_phase = 3;
        default: m_phase = 0;
      endcase
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic run_cycle();
    cycle_begin();
    cycle_end();
  endtask

  task automatic set_all(input int x, input int y, input int it);
    for (int i = 0; i < N; i++) begin
      wx[i] = 10'(x); wy[i] = 10'(y); wit[i] = IW'(it);
    end
  endtask

  task automatic idle_inputs();
    start = 0; valid = '0; ready = 1; set_all(0, 0, 0);
  endtask

  task automatic do_reset();
    rst = 1; run_cycle(); rst = 0;
  endtask

  typedef struct {
    logic start; logic [N-1:0] valid; int x, y, it; logic ready;
    logic [N-1:0] ack; logic fbv; bit chk_ad; int addr, data; logic oob;
  } vec_t;

  vec_t tbl [13];
  int   done_cnt;

  initial begin
    tbl[0]  = '{0, 16'h0000,   0, 0, 'h00, 1, 16'h0000, 0, 1,    0, 'h00, 0};
    tbl[1]  = '{0, 16'h0008,   5, 2, 'h2A, 1, 16'h0000, 0, 1,    0, 'h00, 0};
    tbl[2]  = '{1, 16'h0000,   0, 0, 'h00, 1, 16'h0000, 0, 1,    0, 'h00, 0};
    tbl[3]  = '{0, 16'h0008,   5, 2, 'h2A, 1, 16'h0008, 0, 1,    0, 'h00, 0};
    tbl[4]  = '{0, 16'h0000,   0, 0, 'h00, 1, 16'h0000, 1, 1, 1285, 'h2A, 0};
    tbl[5]  = '{0, 16'h0000,   0, 0, 'h00, 1, 16'h0000, 0, 0,    0, 'h00, 0};
    tbl[6]  = '{1, 16'h0000,   0, 0, 'h00, 1, 16'h0000, 0, 0,    0, 'h00, 0};
    tbl[7]  = '{0, 16'h0008, 640, 0, 'h11, 1, 16'h0008, 0, 0,    0, 'h00, 0};
    tbl[8]  = '{0, 16'h0000,   0, 0, 'h00, 1, 16'h0000, 0, 0,    0, 'h00, 1};
    tbl[9]  = '{0, 16'h0010,   6, 3, 'h77, 1, 16'h0010, 0, 0,    0, 'h00, 1};
    tbl[10] = '{0, 16'h0000,   6, 3, 'h77, 0, 16'h0000, 1, 1, 1926, 'h77, 1};
    tbl[11] = '{0, 16'hFFFF,   6, 3, 'h77, 0, 16'h0000, 1, 1, 1926, 'h77, 1};
    tbl[12] = '{0, 16'hFFFF,   6, 3, 'h77, 1, 16'h0020, 1, 1, 1926, 'h77, 1};

    cyc = 0; hs_total = 0; last_hs_cyc = -10;
    idle_inputs();
    rst = 1;
    @(posedge clk);
    @(negedge clk);
    rst = 0;
    model_reset();

    // Directed table: single pixel latency/address, idle gating, out-of-range discard.
    for (int r = 0; r < 13; r++) begin
      start = tbl[r].start; valid = tbl[r].valid; ready = tbl[r].ready;
      set_all(tbl[r].x, tbl[r].y, tbl[r].it);
      cycle_begin();
      chk($sformatf("tbl%0d_ack", r), 64'(ack), 64'(tbl[r].ack));
      chk($sformatf("tbl%0d_fbv", r), 64'(fbv), 64'(tbl[r].fbv));
      if (tbl[r].chk_ad) begin
        chk($sformatf("tbl%0d_addr", r), 64'(addr), 64'(tbl[r].addr));
        chk($sformatf("tbl%0d_data", r), 64'(data), 64'(tbl[r].data));
      end
      chk($sformatf("tbl%0d_oob", r), 64'(oob), 64'(tbl[r].oob));
      cycle_end();
    end
    idle_inputs();
    run_cycle();
    cycle_begin(); chk("oob_sticky", 64'(oob), 64'd1); cycle_end();
    do_reset();
    cycle_begin(); chk("oob_cleared_by_rst", 64'(oob), 64'd0); cycle_end();

    // Round-robin order with every worker requesting and the frame buffer always ready.
    start = 1; run_cycle(); start = 0;
    valid = '1;
    for (int i = 0; i < N; i++) begin wx[i] = 10'(i); wy[i] = 10'd1; wit[i] = IW'(i); end
    for (int c = 0; c <= N; c++) begin
      cycle_begin();
      chk($sformatf("rr_order%0d", c), 64'(ack), 64'(1) << (c % N));
      cycle_end();
    end

    // Back-pressure: entry from worker 0 (x=0,y=1) must hold for five stalled cycles.
    ready = 0;
    for (int c = 0; c < 5; c++) begin
      cycle_begin();
      chk($sformatf("stall_ack%0d", c), 64'(ack), 64'd0);
      chk($sformatf("stall_addr%0d", c), 64'(addr), 64'd640);
      chk($sformatf("stall_data%0d", c), 64'(data), 64'd0);
      cycle_end();
    end
    ready = 1;
    cycle_begin();
`ifdef RESULT_ARB_STATS_EN
    chk("stall_cycles_5", 64'(stall), 64'd5);
`endif
    chk("stall_release_ack", 64'(ack), 64'h2);
    cycle_end();

    // Reset mid-frame with an entry pending: no further write, arbiter back in idle.
    ready = 0; run_cycle();
    rst = 1; run_cycle(); rst = 0;
    ready = 1;
    cycle_begin();
    chk("rst_mid_fbv", 64'(fbv), 64'd0);
    chk("rst_mid_ack_idle", 64'(ack), 64'd0);
    cycle_end();
    run_cycle();

    // Full randomized frame against the model.
    idle_inputs();
    start = 1; run_cycle(); start = 0;
    hs_total = 0; done_cnt = 0;
    for (int c = 0; c < 20000 && done_cnt == 0; c++) begin
      valid = N'($urandom) & N'($urandom);
      ready = ($urandom % 4) != 0;
      for (int i = 0; i < N; i++) begin
        wx[i]  = ($urandom % 50 == 0) ? 10'(640 + $urandom % 300) : 10'($urandom % (XM + 1));
        wy[i]  = ($urandom % 50 == 0) ? 10'(YM + 1) : 10'($urandom % (YM + 1));
        wit[i] = IW'($urandom);
      end
      cycle_begin();
      if (done) begin
        done_cnt++;
        chk("done_one_after_last_hs", 64'(cyc - last_hs_cyc), 64'd1);
        chk("frame_hs_count", 64'(hs_total), 64'(FRAME));
      end
      cycle_end();
    end
    chk("frame_done_seen", 64'(done_cnt), 64'd1);
    valid = '1;
    cycle_begin();
    chk("frame_done_single", 64'(done), 64'd0);
    chk("idle_after_done_ack", 64'(ack), 64'd0);
    cycle_end();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
